triggered_trace_buffer: RTL
===========================

// Module: triggered_trace_buffer
// PURPOSE
// Multi-mode trace buffer. It captures N-lane vectors from the debug datapath into on-chip dual-port RAM.
// Three capture modes: circular wrap, one-shot fill, and trigger with a post-trigger window.
// Contents are dumped oldest-first through a valid/ready stream to the host readout path.
// It replaces the free-running circular buffer with a frozen-capture and controlled-dump capability.
// PARAMETERS
// N           8    lanes per vector
// DATA_WIDTH  32   bits per lane
// TB_SIZE     64   entries; power of two, >=4
// POST_TRIG   16   entries captured after the trigger entry (mode TRIGGER); 0 <= POST_TRIG < TB_SIZE
// PORTS
// clk         in   1                 clock
// rst_n       in   1                 asynchronous active-low reset
// tracing     in   1                 capture enable
// mode        in   2                 0 WRAP, 1 ONESHOT, 2 TRIGGER, 3 = WRAP; latched on IDLE->CAPTURE
// trigger     in   1                 trigger event (TRIGGER mode)
// valid_in    in   1                 vector_in valid this cycle
// vector_in   in   N x DATA_WIDTH    input vector (unpacked lanes)
// dump_req    in   1                 start dump; honoured only in FROZEN
// out_ready   in   1                 downstream ready
// vector_out  out  N x DATA_WIDTH    dumped entry
// out_valid   out  1                 vector_out valid
// out_last    out  1                 final entry of the dump
// full        out  1                 fill_count == TB_SIZE
// triggered   out  1                 trigger accepted since last capture start
// frozen      out  1                 state == FROZEN
// fill_count  out  clog2(TB_SIZE)+1  valid entries held
// BEHAVIOUR
// - Reset: state IDLE; wr_ptr and fill_count are 0. All outputs are 0, including vector_out. RAM is not cleared.
// - States: IDLE, CAPTURE, POST, FROZEN, DUMP.
// - IDLE -> CAPTURE when tracing=1. On entry, mode is latched, wr_ptr and fill_count are cleared, and triggered is cleared.
// - Writes occur only in CAPTURE or POST, on cycles with valid_in=1.
//   - vector_in is written at wr_ptr.
//   - wr_ptr increments modulo TB_SIZE.
//   - fill_count increments and saturates at TB_SIZE.
// - CAPTURE/POST -> FROZEN when tracing=0. A same-cycle valid_in is not written.
// - WRAP: once full, each write overwrites the oldest entry; capture continues until tracing=0.
// - ONESHOT: the write that makes fill_count reach TB_SIZE is performed, then the state goes to FROZEN.
// - TRIGGER, trigger detection: the first cycle in CAPTURE with trigger=1 sets triggered=1.
//   - If valid_in=1 that cycle, the entry is written as the trigger entry.
//   - Trigger entry not counted in POST_TRIG.
//   - post_cnt is loaded with POST_TRIG.
//   - If POST_TRIG=0 -> FROZEN next; else -> POST.
// - TRIGGER, window: in POST, each write decrements post_cnt; the write at post_cnt==1 -> FROZEN. Further triggers are ignored.
// - FROZEN holds its contents indefinitely. valid_in and trigger are ignored. dump_req -> DUMP.
// - Empty dump: dump_req with fill_count=0 -> IDLE, no out_valid.
// - DUMP read order: rd_ptr starts at wr_ptr if full, else at 0, and reads fill_count entries in order.
//   - RAM read latency is 1. The output register plus a 1-entry skid gives full throughput.
// - DUMP timing: first out_valid is exactly 2 cycles after dump_req is accepted. With out_ready held at 1, one entry per cycle follows.
// - Handshake: a transfer happens on out_valid & out_ready.
//   - While out_valid=1 and out_ready=0, vector_out and out_last are held stable.
//   - out_valid never drops without a transfer.
// - out_last=1 only with the final entry. After its transfer -> IDLE, with fill_count=0 and triggered=0.
// - tracing, trigger and dump_req are ignored in DUMP. Capture restarts only via IDLE.
// - Reset mid-operation: rst_n low drops out_valid and out_last immediately and forces IDLE. After reset, prior data is not dumpable.
// TESTING
// 1. WRAP, TB_SIZE=8: write 1..11, tracing=0 -> full=1, fill_count=8. Dump with out_ready=1 -> 4..11, out_last on 11.
// 2. ONESHOT, TB_SIZE=8: write 1..10 -> frozen after 8th, 9/10 dropped. Dump -> 1..8.
// 3. TRIGGER, TB_SIZE=8, POST_TRIG=3: write 1..20, trigger with 10 -> frozen after 13, triggered=1. Dump -> 6..13.
// 4. Dump of test 1 with random 50% out_ready -> identical 4..11, no loss or duplication, vector_out stable on stalls.
// 5. WRAP write 1..3, stop, dump -> 1,2,3 with out_last on 3. Re-arm and stop with none written, dump_req -> no out_valid, IDLE.
// 6. rst_n low after 2nd dump transfer -> out_valid=0 asynchronously, fill_count=0. New capture of 7,8 dumps as 7,8.

Source files
------------

// File: rtl/triggered_trace_buffer_if.sv
// Readout stream of the trace buffer: one dumped entry per transfer.
// Handshake: a transfer happens on a cycle with out_valid & out_ready; while out_valid=1 and out_ready=0 the producer holds vector_out and out_last stable and never drops out_valid.
interface triggered_trace_buffer_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] vector_out [N];
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (output vector_out, output out_valid, output out_last, input out_ready);
    modport slave  (input vector_out, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/triggered_trace_buffer.sv
// Multi-mode trace buffer: captures N-lane vectors (wrap, one-shot or trigger+post window),
// freezes them and dumps them oldest-first through a valid/ready stream.
module triggered_trace_buffer #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TB_SIZE    = 64,
    parameter int POST_TRIG  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tracing,
    input  logic [1:0]                   mode,
    input  logic                         trigger,
    input  logic                         valid_in,
    input  logic [DATA_WIDTH-1:0]        vector_in [N],
    input  logic                         dump_req,
    output logic                         full,
    output logic                         triggered,
    output logic                         frozen,
    output logic [$clog2(TB_SIZE):0]     fill_count,
    output logic [2:0]                   dbg_state,
    triggered_trace_buffer_if.master     dump_if
);
    localparam int AW = $clog2(TB_SIZE);
    localparam int CW = AW + 1;
    localparam int VW = N * DATA_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(TB_SIZE);
    localparam logic [CW-1:0] LAST_CNT = CW'(TB_SIZE - 1);
    localparam logic [AW-1:0] POST_CNT = AW'(POST_TRIG);
    localparam logic [1:0]    M_ONESHOT = 2'd1;
    localparam logic [1:0]    M_TRIGGER = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_POST    = 3'd2,
        S_FROZEN  = 3'd3,
        S_DUMP    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic            trig_q, trig_d;
    logic [AW-1:0]   post_q, post_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   rd_left_q, rd_left_d;
    logic            rd_vld_q, rd_vld_d;
    logic            rd_last_q, rd_last_d;
    logic [VW-1:0]   out_data_q, out_data_d;
    logic            out_vld_q, out_vld_d;
    logic            out_last_q, out_last_d;
    logic [VW-1:0]   sk_data_q, sk_data_d;
    logic            sk_vld_q, sk_vld_d;
    logic            sk_last_q, sk_last_d;

    logic [VW-1:0]   mem [TB_SIZE];
    logic [VW-1:0]   rd_data_q;
    logic [VW-1:0]   wr_data;
    logic            we, rd_en, pop, is_full;
    logic [1:0]      occ;

    always_comb begin
        wr_data = '0;
        for (int i = 0; i < N; i++) begin
            wr_data[i*DATA_WIDTH +: DATA_WIDTH] = vector_in[i];
        end
    end

    assign is_full = (fill_q == FULL_CNT);
    assign pop     = out_vld_q & dump_if.out_ready;
    assign occ     = {1'b0, out_vld_q} + {1'b0, sk_vld_q} + {1'b0, rd_vld_q};

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        trig_d     = trig_q;
        post_d     = post_q;
        rd_ptr_d   = rd_ptr_q;
        rd_left_d  = rd_left_q;
        rd_vld_d   = 1'b0;
        rd_last_d  = rd_last_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        sk_data_d  = sk_data_q;
        sk_vld_d   = sk_vld_q;
        sk_last_d  = sk_last_q;
        we         = 1'b0;
        rd_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tracing) begin
                    state_d  = S_CAPTURE;
                    mode_d   = mode;
                    wr_ptr_d = '0;
                    fill_d   = '0;
                    trig_d   = 1'b0;
                end
            end
            S_CAPTURE, S_POST: begin
                if (!tracing) begin
                    state_d = S_FROZEN;
                end else begin
                    if (valid_in) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (!is_full) fill_d = fill_q + 1'b1;
                    end
                    if (state_q == S_CAPTURE) begin
                        if (mode_q == M_ONESHOT && valid_in && fill_q == LAST_CNT) begin
                            state_d = S_FROZEN;
                        end
                        // Trigger entry itself is not part of the post window.
                        if (mode_q == M_TRIGGER && trigger) begin
                            trig_d  = 1'b1;
                            post_d  = POST_CNT;
                            state_d = (POST_TRIG == 0) ? S_FROZEN : S_POST;
                        end
                    end else if (valid_in) begin
                        post_d = post_q - 1'b1;
                        if (post_q == AW'(1)) state_d = S_FROZEN;
                    end
                end
            end
            S_FROZEN: begin
                if (dump_req) begin
                    if (fill_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DUMP;
                        rd_ptr_d  = is_full ? wr_ptr_q : '0;
                        rd_left_d = fill_q;
                    end
                end
            end
            S_DUMP: begin
                // Only issue a read if out+skid can absorb everything already in flight.
                if (rd_left_q != '0 && (occ - {1'b0, pop}) < 2'd2) begin
                    rd_en     = 1'b1;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    rd_left_d = rd_left_q - 1'b1;
                    rd_vld_d  = 1'b1;
                    rd_last_d = (rd_left_q == CW'(1));
                end
                if (!out_vld_q || pop) begin
                    if (sk_vld_q) begin
                        out_data_d = sk_data_q;
                        out_last_d = sk_last_q;
                        out_vld_d  = 1'b1;
                        sk_vld_d   = rd_vld_q;
                        sk_data_d  = rd_vld_q ? rd_data_q : sk_data_q;
                        sk_last_d  = rd_vld_q ? rd_last_q : sk_last_q;
                    end else if (rd_vld_q) begin
                        out_data_d = rd_data_q;
                        out_last_d = rd_last_q;
                        out_vld_d  = 1'b1;
                    end else begin
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                    end
                end else if (rd_vld_q) begin
                    sk_data_d = rd_data_q;
                    sk_last_d = rd_last_q;
                    sk_vld_d  = 1'b1;
                end
                if (pop && out_last_q) begin
                    state_d = S_IDLE;
                    fill_d  = '0;
                    trig_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            trig_q     <= 1'b0;
            post_q     <= '0;
            rd_ptr_q   <= '0;
            rd_left_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            sk_data_q  <= '0;
            sk_vld_q   <= 1'b0;
            sk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            trig_q     <= trig_d;
            post_q     <= post_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_left_q  <= rd_left_d;
            rd_vld_q   <= rd_vld_d;
            rd_last_q  <= rd_last_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            sk_data_q  <= sk_data_d;
            sk_vld_q   <= sk_vld_d;
            sk_last_q  <= sk_last_d;
        end
    end

    // Storage is deliberately not reset; fill_count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_ptr_q];
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign dump_if.vector_out[g] = out_data_q[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign dump_if.out_valid = out_vld_q;
    assign dump_if.out_last  = out_last_q;
    assign full       = is_full;
    assign triggered  = trig_q;
    assign frozen     = (state_q == S_FROZEN);
    assign fill_count = fill_q;
    assign dbg_state  = state_q;
endmodule
